dmem_responder: RTL

- Data-memory responder for the core's dmem request/response protocol; the memory-side end of the execute stage's load/store path.
- Used as a scratchpad stand-in for the L1 data cache in core-level simulation and small FPGA builds.
- Accepts one request at a time, checks alignment and range, services loads, stores, LR and SC from an internal word array, and returns a fixed-latency response with the tag echoed back.

---
 rtl/drac_pkg.sv | 81 ++++++++
 rtl/dmem_load_align.sv | 30 +++
 rtl/dmem_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/drac_pkg.sv
// Shared definitions for the dmem request/response path: command and size
// encodings, request/response records, responder FSM states and small helpers.
package drac_pkg;

    typedef enum logic [4:0] {
        DMEM_CMD_RD = 5'd0,
        DMEM_CMD_WR = 5'd1,
        DMEM_CMD_LR = 5'd6,
        DMEM_CMD_SC = 5'd7
    } dmem_cmd_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } dmem_size_e;

    typedef struct packed {
        dmem_cmd_e   cmd;
        logic [39:0] addr;
        dmem_size_e  size;
        logic        is_unsigned;
        logic [63:0] data;
        logic [7:0]  tag;
    } dmem_req_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
        logic [7:0]  tag;
        logic        nack;
        logic        ma_ld;
        logic        ma_st;
        logic        pf_ld;
        logic        pf_st;
    } dmem_resp_t;

    typedef enum logic [1:0] {
        RESP_IDLE = 2'd0,
        RESP_S1   = 2'd1,
        RESP_WAIT = 2'd2,
        RESP_RESP = 2'd3
    } resp_state_e;

    // Unknown command codes behave as plain reads.
    function automatic dmem_cmd_e decode_cmd(input logic [4:0] raw);
        case (raw)
            5'd1:    return DMEM_CMD_WR;
            5'd6:    return DMEM_CMD_LR;
            5'd7:    return DMEM_CMD_SC;
            default: return DMEM_CMD_RD;
        endcase
    endfunction

    function automatic logic is_store(input dmem_cmd_e cmd);
        return (cmd == DMEM_CMD_WR) || (cmd == DMEM_CMD_SC);
    endfunction

    function automatic logic is_aligned(input dmem_size_e size, input logic [2:0] off);
        case (size)
            SIZE_B:  return 1'b1;
            SIZE_H:  return (off[0] == 1'b0);
            SIZE_W:  return (off[1:0] == 2'b00);
            SIZE_D:  return (off == 3'b000);
            default: return 1'b0;
        endcase
    endfunction

    // Byte-lane mask of an access of the given size, before lane shifting.
    function automatic logic [63:0] size_mask(input dmem_size_e size);
        case (size)
            SIZE_B:  return 64'h0000_0000_0000_00FF;
            SIZE_H:  return 64'h0000_0000_0000_FFFF;
            SIZE_W:  return 64'h0000_0000_FFFF_FFFF;
            SIZE_D:  return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return 64'h0000_0000_0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load-data aligner: selects the addressed lane of a 64-bit word and
// sign- or zero-extends it to 64 bits according to the access size.
module dmem_load_align
    import drac_pkg::*;
(
    input  logic [63:0] word_i,
    input  logic [2:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [63:0] data_o
);

    logic [63:0] shifted_s;

    // Shift the selected lane down to bit 0 and extend it.
    always_comb begin
        shifted_s = word_i >> {offset_i, 3'b000};
        case (size_i)
            SIZE_B:  data_o = unsigned_i ? {56'd0, shifted_s[7:0]}
                                         : {{56{shifted_s[7]}}, shifted_s[7:0]};
            SIZE_H:  data_o = unsigned_i ? {48'd0, shifted_s[15:0]}
                                         : {{48{shifted_s[15]}}, shifted_s[15:0]};
            SIZE_W:  data_o = unsigned_i ? {32'd0, shifted_s[31:0]}
                                         : {{32{shifted_s[31]}}, shifted_s[31:0]};
            SIZE_D:  data_o = shifted_s;
            default: data_o = shifted_s;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: scratchpad stand-in for the L1 data cache. Accepts one
// request at a time, checks alignment and range, services RD/WR/LR/SC from an
// internal word array and answers after a fixed latency.
// Optional build macro DMEM_RESPONDER_NACK_INJECT_EN enables LFSR-driven nacks.
module dmem_responder
    import drac_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dmem_req_valid_i,
    output logic        dmem_req_ready_o,
    input  logic [4:0]  dmem_req_cmd_i,
    input  logic [39:0] dmem_req_addr_i,
    input  logic [63:0] dmem_op_type_i,
    input  logic [63:0] dmem_req_data_i,
    input  logic [7:0]  dmem_req_tag_i,
    input  logic        dmem_req_invalidate_lr_i,
    input  logic        dmem_req_kill_i,
    output logic        dmem_resp_valid_o,
    output logic [63:0] dmem_resp_data_o,
    output logic [7:0]  dmem_resp_tag_o,
    output logic        dmem_resp_nack_o,
    output logic        dmem_resp_replay_o,
    output logic        dmem_xcpt_ma_ld_o,
    output logic        dmem_xcpt_ma_st_o,
    output logic        dmem_xcpt_pf_ld_o,
    output logic        dmem_xcpt_pf_st_o
);

    localparam int          IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [39:0] ADDR_LIMIT = 40'(DEPTH) << 3;

    resp_state_e        state_r, state_next_s;
    logic [3:0]         cnt_r, cnt_next_s;
    logic               ready_r;
    dmem_req_t          req_r;
    dmem_resp_t         resp_r, resp_next_s;
    logic               rsv_valid_r, rsv_valid_next_s;
    logic [IDX_W-1:0]   rsv_idx_r, rsv_idx_next_s;
    logic [63:0]        mem_r [DEPTH];
    logic               mem_we_s;
    logic [IDX_W-1:0]   idx_s;
    logic [63:0]        rd_word_s, wr_word_s, lane_mask_s, load_data_s;
    logic               accept_s, nack_inject_s, sc_ok_s;
    logic               unused_op_s;

    assign accept_s    = dmem_req_valid_i && ready_r;
    assign idx_s       = req_r.addr[IDX_W+2:3];
    assign rd_word_s   = mem_r[idx_s];
    assign lane_mask_s = size_mask(req_r.size) << {req_r.addr[2:0], 3'b000};
    assign wr_word_s   = (rd_word_s & ~lane_mask_s)
                       | ((req_r.data << {req_r.addr[2:0], 3'b000}) & lane_mask_s);
    assign sc_ok_s     = rsv_valid_r && (rsv_idx_r == idx_s) && !dmem_req_invalidate_lr_i;
    assign unused_op_s = ^dmem_op_type_i[63:3];

    dmem_load_align u_load_align (
        .word_i     (rd_word_s),
        .offset_i   (req_r.addr[2:0]),
        .size_i     (req_r.size),
        .unsigned_i (req_r.is_unsigned),
        .data_o     (load_data_s)
    );

`ifdef DMEM_RESPONDER_NACK_INJECT_EN
    logic [15:0] lfsr_r;

    // Free-running Fibonacci LFSR (taps 16,14,13,11) choosing which responses to nack.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end
    end
    assign nack_inject_s = lfsr_r[0];
`else
    assign nack_inject_s = 1'b0;
`endif

    // Capture the request fields on the accept edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_r <= '0;
        end else if (accept_s) begin
            req_r.cmd         <= decode_cmd(dmem_req_cmd_i);
            req_r.addr        <= dmem_req_addr_i;
            req_r.size        <= dmem_size_e'(dmem_op_type_i[1:0]);
            req_r.is_unsigned <= dmem_op_type_i[2];
            req_r.data        <= dmem_req_data_i;
            req_r.tag         <= dmem_req_tag_i;
        end else begin
            req_r <= req_r;
        end
    end

    // FSM state, latency counter, reservation and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= RESP_IDLE;
            cnt_r       <= 4'd0;
            ready_r     <= 1'b1;
            rsv_valid_r <= 1'b0;
            rsv_idx_r   <= '0;
            resp_r      <= '0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            ready_r     <= (state_next_s == RESP_IDLE);
            rsv_valid_r <= rsv_valid_next_s;
            rsv_idx_r   <= rsv_idx_next_s;
            resp_r      <= resp_next_s;
        end
    end

    // Next-state, response and commit decisions; writes happen only on the RESP edge.
    always_comb begin
        state_next_s     = state_r;
        cnt_next_s       = cnt_r;
        resp_next_s      = '0;
        mem_we_s         = 1'b0;
        rsv_valid_next_s = rsv_valid_r;
        rsv_idx_next_s   = rsv_idx_r;
        case (state_r)
            RESP_IDLE: begin
                if (accept_s) begin
                    state_next_s = RESP_S1;
                end else begin
                    state_next_s = RESP_IDLE;
                end
            end
            RESP_S1: begin
                if (dmem_req_kill_i) begin
                    state_next_s = RESP_IDLE;
                end else if (!is_aligned(req_r.size, req_r.addr[2:0])) begin
                    resp_next_s.ma_ld = !is_store(req_r.cmd);
                    resp_next_s.ma_st = is_store(req_r.cmd);
                    state_next_s      = RESP_IDLE;
                end else if (req_r.addr >= ADDR_LIMIT) begin
                    resp_next_s.pf_ld = !is_store(req_r.cmd);
                    resp_next_s.pf_st = is_store(req_r.cmd);
                    state_next_s      = RESP_IDLE;
                end else if (LATENCY == 2) begin
                    state_next_s = RESP_RESP;
                end else begin
                    cnt_next_s   = 4'(LATENCY - 2);
                    state_next_s = RESP_WAIT;
                end
            end
            RESP_WAIT: begin
                cnt_next_s = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    state_next_s = RESP_RESP;
                end else begin
                    state_next_s = RESP_WAIT;
                end
            end
            RESP_RESP: begin
                state_next_s    = RESP_IDLE;
                resp_next_s.tag = req_r.tag;
                if (nack_inject_s) begin
                    resp_next_s.nack = 1'b1;
                end else begin
                    resp_next_s.valid = 1'b1;
                    case (req_r.cmd)
                        DMEM_CMD_WR: begin
                            mem_we_s         = 1'b1;
                            resp_next_s.data = 64'd0;
                            if (rsv_idx_r == idx_s) begin
                                rsv_valid_next_s = 1'b0;
                            end else begin
                                rsv_valid_next_s = rsv_valid_r;
                            end
                        end
                        DMEM_CMD_LR: begin
                            resp_next_s.data = load_data_s;
                            rsv_valid_next_s = 1'b1;
                            rsv_idx_next_s   = idx_s;
                        end
                        DMEM_CMD_SC: begin
                            mem_we_s         = sc_ok_s;
                            resp_next_s.data = sc_ok_s ? 64'd0 : 64'd1;
                            rsv_valid_next_s = 1'b0;
                        end
                        default: begin
                            resp_next_s.data = load_data_s;
                        end
                    endcase
                end
            end
            default: begin
                state_next_s = RESP_IDLE;
            end
        endcase
        // An invalidate always wins over a reservation set in the same cycle.
        if (dmem_req_invalidate_lr_i) begin
            rsv_valid_next_s = 1'b0;
        end else begin
            rsv_valid_next_s = rsv_valid_next_s;
        end
    end

    // Word array write port; contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            mem_r[idx_s] <= wr_word_s;
        end else begin
            mem_r[idx_s] <= mem_r[idx_s];
        end
    end

    assign dmem_req_ready_o   = ready_r;
    assign dmem_resp_valid_o  = resp_r.valid;
    assign dmem_resp_data_o   = resp_r.data;
    assign dmem_resp_tag_o    = resp_r.tag;
    assign dmem_resp_nack_o   = resp_r.nack;
    assign dmem_resp_replay_o = 1'b0;
    assign dmem_xcpt_ma_ld_o  = resp_r.ma_ld;
    assign dmem_xcpt_ma_st_o  = resp_r.ma_st;
    assign dmem_xcpt_pf_ld_o  = resp_r.pf_ld;
    assign dmem_xcpt_pf_st_o  = resp_r.pf_st;

endmodule
